// File: rtl/hazard_flush_ctrl.sv
// Decode-side sequencing: scoreboard RAW interlock, jump squash train
// and memory-wait freeze for the front end.
module hazard_flush_ctrl #(
  parameter int DEPTH         = 3,
  parameter bit WB_BYPASS     = 1'b1,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       a0,
  input  logic [4:0]       a1,
  input  logic             use_a0,
  input  logic             use_a1,
  input  logic [4:0]       a2_hazard,
  input  logic             jmp_taken,
  input  logic             mem_wait,
  output logic             stall,
  output logic             hold_front,
  output logic             bubble,
  output logic             squash,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] hazard_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HAZ   = 2'd1,
    S_FLUSH = 2'd2,
    S_MEMW  = 2'd3
  } state_t;

  localparam int NCHK = WB_BYPASS ? DEPTH - 1 : DEPTH;
  localparam logic [2:0] FL_LOAD = 3'(SQUASH_CYCLES - 1);

  logic [DEPTH-1:0]      sb_v;
  logic [DEPTH-1:0][4:0] sb_r;
  logic [2:0]            flush_cnt;
  logic                  hit0;
  logic                  hit1;
  logic                  haz;
  state_t                st;

  // writeback slot is skipped when the regfile forwards its write
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < NCHK; i++) begin
      if (sb_v[i] && sb_r[i] == a0) hit0 = 1'b1;
      if (sb_v[i] && sb_r[i] == a1) hit1 = 1'b1;
    end
  end

  assign haz = rst &
               ((use_a0 & (a0 != 5'd0) & hit0) |
                (use_a1 & (a1 != 5'd0) & hit1));

  assign stall      = rst & mem_wait;
  assign squash     = rst & ~mem_wait &
                      (jmp_taken | (flush_cnt != 3'd0));
  assign bubble     = ~stall & ~squash & haz;
  assign hold_front = bubble;

  always_comb begin
    st = S_RUN;
    unique case (1'b1)
      stall:   st = S_MEMW;
      squash:  st = S_FLUSH;
      bubble:  st = S_HAZ;
      default: st = S_RUN;
    endcase
  end

  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v       <= '0;
      sb_r       <= '0;
      flush_cnt  <= 3'd0;
      hazard_cnt <= '0;
    end else if (!stall) begin
      sb_v[0] <= (a2_hazard != 5'd0) & ~bubble & ~squash;
      sb_r[0] <= a2_hazard;
      for (int i = 1; i < DEPTH; i++) begin
        sb_v[i] <= sb_v[i-1];
        sb_r[i] <= sb_r[i-1];
      end
      if (jmp_taken)
        flush_cnt <= FL_LOAD;
      else if (flush_cnt != 3'd0)
        flush_cnt <= flush_cnt - 3'd1;
      if (bubble && hazard_cnt != '1)
        hazard_cnt <= hazard_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed vector bench for hazard_flush_ctrl: bypass and
// non-bypass instances driven from one shared stimulus.
module tb_hazard_flush_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] a0 = '0, a1 = '0, a2_hazard = '0;
  logic use_a0 = 1'b0, use_a1 = 1'b0;
  logic jmp_taken = 1'b0, mem_wait = 1'b0;

  logic b_stall, b_hold, b_bub, b_sq;
  logic [1:0] b_state;
  logic [15:0] b_cnt;
  logic n_stall, n_hold, n_bub, n_sq;
  logic [1:0] n_state;
  logic [1:0] n_cnt;

  always #5 clk = ~clk;

  hazard_flush_ctrl u_byp (
    .clk(clk), .rst(rst), .a0(a0), .a1(a1),
    .use_a0(use_a0), .use_a1(use_a1), .a2_hazard(a2_hazard),
    .jmp_taken(jmp_taken), .mem_wait(mem_wait),
    .stall(b_stall), .hold_front(b_hold), .bubble(b_bub),
    .squash(b_sq), .state(b_state), .hazard_cnt(b_cnt)
  );

  hazard_flush_ctrl #(.WB_BYPASS(1'b0), .CNT_W(2)) u_nob (
    .clk(clk), .rst(rst), .a0(a0), .a1(a1),
    .use_a0(use_a0), .use_a1(use_a1), .a2_hazard(a2_hazard),
    .jmp_taken(jmp_taken), .mem_wait(mem_wait),
    .stall(n_stall), .hold_front(n_hold), .bubble(n_bub),
    .squash(n_sq), .state(n_state), .hazard_cnt(n_cnt)
  );

  // {stall, hold_front, bubble, squash, state}
  localparam logic [5:0] O_RUN = 6'b0000_00;
  localparam logic [5:0] O_HAZ = 6'b0110_01;
  localparam logic [5:0] O_FL  = 6'b0001_10;
  localparam logic [5:0] O_MW  = 6'b1000_11;

  typedef struct {
    logic [4:0]  a0;
    logic        u0;
    logic [4:0]  a1;
    logic        u1;
    logic [4:0]  a2;
    logic        jmp;
    logic        mw;
    logic [5:0]  exp;
    logic [15:0] cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    logic [4:0] x0, logic u0, logic [4:0] x1, logic u1,
    logic [4:0] x2, logic j, logic m, logic [5:0] e, logic [15:0] c
  );
    vec_t v;
    v.a0 = x0; v.u0 = u0; v.a1 = x1; v.u1 = u1; v.a2 = x2;
    v.jmp = j; v.mw = m; v.exp = e; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    a0 = v.a0; use_a0 = v.u0; a1 = v.a1; use_a1 = v.u1;
    a2_hazard = v.a2; jmp_taken = v.jmp; mem_wait = v.mw;
  endtask

  task automatic run(string nm, vec_t v, bit nob);
    drive(v);
    @(negedge clk);
    if (nob) begin
      chk({nm, "_out"}, {26'd0, n_stall, n_hold, n_bub, n_sq, n_state},
          {26'd0, v.exp});
      chk({nm, "_cnt"}, {30'd0, n_cnt}, {16'd0, v.cnt});
    end else begin
      chk({nm, "_out"}, {26'd0, b_stall, b_hold, b_bub, b_sq, b_state},
          {26'd0, v.exp});
      chk({nm, "_cnt"}, {16'd0, b_cnt}, {16'd0, v.cnt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0,0,O_RUN,0));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // outputs forced low in reset even with active inputs
    drive(mk(5,1,5,1,5,1,1,O_RUN,0));
    @(negedge clk);
    chk("rst_force_b", {26'd0, b_stall, b_hold, b_bub, b_sq, b_state}, 0);
    chk("rst_force_n", {26'd0, n_stall, n_hold, n_bub, n_sq, n_state}, 0);
    do_reset();

    for (int i = 0; i < 10; i++)
      run($sformatf("idle%0d", i), mk(0,0,0,0,0,0,0,O_RUN,0), 1'b0);

    tbl.push_back(mk(0,0,0,0,5,0,0,O_RUN,0));
    tbl.push_back(mk(5,1,0,0,0,0,0,O_HAZ,0));
    tbl.push_back(mk(5,1,0,0,0,0,0,O_HAZ,1));
    tbl.push_back(mk(5,1,0,0,0,0,0,O_RUN,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,O_RUN,2));
    tbl.push_back(mk(0,1,0,0,0,0,0,O_RUN,2));
    tbl.push_back(mk(0,0,0,0,7,0,0,O_RUN,2));
    tbl.push_back(mk(0,0,7,0,0,0,0,O_RUN,2));
    tbl.push_back(mk(0,0,7,1,0,0,0,O_HAZ,2));
    tbl.push_back(mk(0,0,7,1,0,0,0,O_RUN,3));
    tbl.push_back(mk(0,0,0,0,9,1,0,O_FL,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,O_FL,3));
    tbl.push_back(mk(9,1,0,0,0,0,0,O_RUN,3));
    tbl.push_back(mk(0,0,0,0,0,1,0,O_FL,3));
    tbl.push_back(mk(0,0,0,0,0,1,0,O_FL,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,O_FL,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,O_RUN,3));
    tbl.push_back(mk(0,0,0,0,4,0,0,O_RUN,3));
    tbl.push_back(mk(4,1,0,0,0,1,0,O_FL,3));
    tbl.push_back(mk(4,1,0,0,0,0,0,O_FL,3));
    tbl.push_back(mk(4,1,0,0,0,0,0,O_RUN,3));
    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i], 1'b0);

    // freeze with a producer in flight; jump during freeze is dropped
    run("frz_prod", mk(0,0,0,0,3,0,0,O_RUN,3), 1'b0);
    run("frz1", mk(3,1,0,0,0,0,1,O_MW,3), 1'b0);
    run("frz2", mk(3,1,0,0,0,1,1,O_MW,3), 1'b0);
    run("frz3", mk(3,1,0,0,0,0,1,O_MW,3), 1'b0);
    run("frz4", mk(3,1,0,0,0,0,1,O_MW,3), 1'b0);
    run("post1", mk(3,1,0,0,0,0,0,O_HAZ,3), 1'b0);
    run("post2", mk(3,1,0,0,0,0,0,O_HAZ,4), 1'b0);
    run("post3", mk(3,1,0,0,0,0,0,O_RUN,5), 1'b0);

    // async reset in the middle of a freeze
    run("rz_prod", mk(0,0,0,0,6,0,0,O_RUN,5), 1'b0);
    drive(mk(6,1,0,0,0,1,1,O_MW,5));
    @(negedge clk);
    chk("rz_frz", {26'd0, b_stall, b_hold, b_bub, b_sq, b_state},
        {26'd0, O_MW});
    #1 rst = 1'b0;
    #1;
    chk("rz_out", {26'd0, b_stall, b_hold, b_bub, b_sq, b_state}, 0);
    chk("rz_cnt", {16'd0, b_cnt}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    run("rz_after", mk(6,1,0,0,0,0,0,O_RUN,0), 1'b0);

    // no bypass: three bubbles, then counter saturates at 3
    do_reset();
    run("nb_prod", mk(0,0,0,0,5,0,0,O_RUN,0), 1'b1);
    run("nb1", mk(5,1,0,0,0,0,0,O_HAZ,0), 1'b1);
    run("nb2", mk(5,1,0,0,0,0,0,O_HAZ,1), 1'b1);
    run("nb3", mk(5,1,0,0,0,0,0,O_HAZ,2), 1'b1);
    run("nb4", mk(5,1,0,0,0,0,0,O_RUN,3), 1'b1);
    run("sat_prod", mk(0,0,0,0,8,0,0,O_RUN,3), 1'b1);
    run("sat1", mk(0,0,8,1,0,0,0,O_HAZ,3), 1'b1);
    run("sat2", mk(0,0,8,1,0,0,0,O_HAZ,3), 1'b1);
    run("sat3", mk(0,0,8,1,0,0,0,O_HAZ,3), 1'b1);
    run("sat4", mk(0,0,8,1,0,0,0,O_RUN,3), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
